branch_predictor: RTL and testbench

Responder side of the fetcher↔predictor interface. It answers taken/not-taken prediction requests for conditional branches and trains itself on resolved-branch feedback. Storage is a direct-mapped branch history table (BHT) of 2-bit saturating counters indexed by PC. It sits beside the instruction fetcher: requests and feedback come from the fetcher, and responses go back to it.

---
 rtl/branch_predictor_pkg.sv | 23 ++
 rtl/branch_predictor_if.sv | 24 ++
 rtl/branch_predictor_pd_sat_counter2.sv | 20 ++
 rtl/branch_predictor.sv | 109 ++++++++++
 tb/tb_branch_predictor.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared counter encodings and request FSM states for the branch predictor
package branch_predictor_pkg;

  typedef logic [1:0] bht_cnt_t;

  // 2-bit saturating counter encodings
  localparam bht_cnt_t SNT = 2'b00;
  localparam bht_cnt_t WNT = 2'b01;
  localparam bht_cnt_t WT  = 2'b10;
  localparam bht_cnt_t ST  = 2'b11;

  localparam bht_cnt_t BHT_RESET_VALUE = WNT;

  // Request FSM states; IDLE is the armed state
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_DROP = 1'b1;

  // The upper counter bit is the taken/not-taken prediction
  function automatic logic cnt_predicts_taken(input bht_cnt_t cnt);
    return cnt[1];
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetcher to predictor request/feedback/response bundle
interface branch_predictor_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  IFPD_predict_en;
  logic [ADDR_WIDTH-1:0] IFPD_pc;
  logic                  IFPD_feedback_en;
  logic                  IFPD_branch_result;
  logic [ADDR_WIDTH-1:0] IFPD_feedback_pc;
  logic                  PDIF_en;
  logic                  PDIF_predict_result;

  // Fetcher side: issues requests and feedback, consumes responses
  modport master (
    output IFPD_predict_en, IFPD_pc, IFPD_feedback_en, IFPD_branch_result, IFPD_feedback_pc,
    input  PDIF_en, PDIF_predict_result
  );

  // Predictor side: answers requests and absorbs feedback
  modport slave (
    input  IFPD_predict_en, IFPD_pc, IFPD_feedback_en, IFPD_branch_result, IFPD_feedback_pc,
    output PDIF_en, PDIF_predict_result
  );
endinterface

// File: rtl/branch_predictor_pd_sat_counter2.sv
// rtl/branch_predictor_pd_sat_counter2.sv - 2-bit saturating counter next-value function
module pd_sat_counter2
  import branch_predictor_pkg::*;
(
  input  bht_cnt_t cur,
  input  logic     taken,
  output bht_cnt_t next
);

  // Step toward ST on taken, toward SNT on not taken, clamping at the ends
  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != ST) next = cur + 2'b01;
    end else begin
      if (cur != SNT) next = cur - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BHT branch predictor responder; optional gshare indexing via BRANCH_PREDICTOR_GSHARE_EN
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int BHT_INDEX_WIDTH = 8
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  IFPD_predict_en,
  input  logic [ADDR_WIDTH-1:0] IFPD_pc,
  input  logic                  IFPD_feedback_en,
  input  logic                  IFPD_branch_result,
  input  logic [ADDR_WIDTH-1:0] IFPD_feedback_pc,
  output logic                  PDIF_en,
  output logic                  PDIF_predict_result
);

  localparam int BHT_ENTRIES = 1 << BHT_INDEX_WIDTH;

  bht_cnt_t bht_q [BHT_ENTRIES];
  bht_cnt_t bht_d [BHT_ENTRIES];

  logic [0:0]                 state_q, state_d;
  logic                       pdif_en_q, pdif_en_d;
  logic                       pdif_res_q, pdif_res_d;
  logic [BHT_INDEX_WIDTH-1:0] pred_idx, upd_idx;
  bht_cnt_t                   upd_next;

  // Word-aligned PC bits select the entry; low bits and high bits beyond the index are don't-care
  logic unused_pc_bits;
  assign unused_pc_bits = ^{IFPD_pc[ADDR_WIDTH-1:BHT_INDEX_WIDTH+2], IFPD_pc[1:0],
                            IFPD_feedback_pc[ADDR_WIDTH-1:BHT_INDEX_WIDTH+2], IFPD_feedback_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [BHT_INDEX_WIDTH-1:0] ghr_q, ghr_d;

  // Both lookup and training hash with the history as it stands this cycle
  assign pred_idx = IFPD_pc[BHT_INDEX_WIDTH+1:2] ^ ghr_q;
  assign upd_idx  = IFPD_feedback_pc[BHT_INDEX_WIDTH+1:2] ^ ghr_q;

  // Shift resolved outcomes into history; only committed branches, never speculative
  always_comb begin
    ghr_d = ghr_q;
    if (Sys_rdy && IFPD_feedback_en) ghr_d = {ghr_q[BHT_INDEX_WIDTH-2:0], IFPD_branch_result};
  end

  // History register
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) ghr_q <= '0;
    else         ghr_q <= ghr_d;
  end
`else
  assign pred_idx = IFPD_pc[BHT_INDEX_WIDTH+1:2];
  assign upd_idx  = IFPD_feedback_pc[BHT_INDEX_WIDTH+1:2];
`endif

  pd_sat_counter2 u_sat_counter (
    .cur   (bht_q[upd_idx]),
    .taken (IFPD_branch_result),
    .next  (upd_next)
  );

  // Training: one counter write per feedback strobe, dropped while stalled
  always_comb begin
    bht_d = bht_q;
    if (Sys_rdy && IFPD_feedback_en) bht_d[upd_idx] = upd_next;
  end

  // Request FSM: one response pulse per request, re-armed only after the request drops
  always_comb begin
    state_d    = state_q;
    pdif_en_d  = pdif_en_q;
    pdif_res_d = pdif_res_q;
    if (Sys_rdy) begin
      pdif_en_d = 1'b0;
      if (state_q == IDLE) begin
        if (IFPD_predict_en) begin
          // Reads the pre-update counter even when feedback hits the same entry
          pdif_en_d  = 1'b1;
          pdif_res_d = cnt_predicts_taken(bht_q[pred_idx]);
          state_d    = WAIT_DROP;
        end
      end else if (!IFPD_predict_en) begin
        state_d = IDLE;
      end
    end
  end

  // Table and FSM state registers
  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_RESET_VALUE;
      state_q    <= IDLE;
      pdif_en_q  <= 1'b0;
      pdif_res_q <= 1'b0;
    end else begin
      bht_q      <= bht_d;
      state_q    <= state_d;
      pdif_en_q  <= pdif_en_d;
      pdif_res_q <= pdif_res_d;
    end
  end

  assign PDIF_en             = pdif_en_q;
  assign PDIF_predict_result = pdif_res_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor against a behavioural model
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_WIDTH(32)) bp_if ();

  branch_predictor #(.ADDR_WIDTH(32), .BHT_INDEX_WIDTH(8)) dut (
    .Sys_clk             (clk),
    .Sys_rst             (rst),
    .Sys_rdy             (rdy),
    .IFPD_predict_en     (bp_if.IFPD_predict_en),
    .IFPD_pc             (bp_if.IFPD_pc),
    .IFPD_feedback_en    (bp_if.IFPD_feedback_en),
    .IFPD_branch_result  (bp_if.IFPD_branch_result),
    .IFPD_feedback_pc    (bp_if.IFPD_feedback_pc),
    .PDIF_en             (bp_if.PDIF_en),
    .PDIF_predict_result (bp_if.PDIF_predict_result)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: counters as plain integers 0..3, an armed flag, and history
  int m_cnt [256];
  bit m_armed;
  bit m_en;
  bit m_res;
  int m_ghr;

  function automatic int model_idx(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) & 32'hFF);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge, then compare outputs just after the edge
  task automatic cycle();
    int pi, fi, c;
    if (rst) begin
      for (int i = 0; i < 256; i++) m_cnt[i] = 1;
      m_armed = 1'b1;
      m_en    = 1'b0;
      m_res   = 1'b0;
      m_ghr   = 0;
    end else if (rdy) begin
      pi = model_idx(bp_if.IFPD_pc);
      fi = model_idx(bp_if.IFPD_feedback_pc);
      m_en = 1'b0;
      if (m_armed) begin
        if (bp_if.IFPD_predict_en) begin
          m_en    = 1'b1;
          m_res   = (m_cnt[pi] >= 2);
          m_armed = 1'b0;
        end
      end else if (!bp_if.IFPD_predict_en) begin
        m_armed = 1'b1;
      end
      if (bp_if.IFPD_feedback_en) begin
        c = m_cnt[fi];
        m_cnt[fi] = bp_if.IFPD_branch_result ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
        m_ghr = ((m_ghr << 1) | int'(bp_if.IFPD_branch_result)) & 255;
      end
    end
    @(posedge clk);
    #1;
    chk("model_en", bp_if.PDIF_en, m_en);
    chk("model_res", bp_if.PDIF_predict_result, m_res);
  endtask

  task automatic feedback(input logic [31:0] pc, input logic taken);
    bp_if.IFPD_feedback_en   = 1'b1;
    bp_if.IFPD_feedback_pc   = pc;
    bp_if.IFPD_branch_result = taken;
    cycle();
    bp_if.IFPD_feedback_en   = 1'b0;
  endtask

  task automatic request(input string tag, input logic [31:0] pc, input logic exp_res);
    bp_if.IFPD_predict_en = 1'b1;
    bp_if.IFPD_pc         = pc;
    cycle();
    chk({tag, "_en"}, bp_if.PDIF_en, 1'b1);
    chk({tag, "_res"}, bp_if.PDIF_predict_result, exp_res);
    bp_if.IFPD_predict_en = 1'b0;
    cycle();
    chk({tag, "_drop"}, bp_if.PDIF_en, 1'b0);
  endtask

  initial begin
    bp_if.IFPD_predict_en    = 1'b0;
    bp_if.IFPD_pc            = '0;
    bp_if.IFPD_feedback_en   = 1'b0;
    bp_if.IFPD_branch_result = 1'b0;
    bp_if.IFPD_feedback_pc   = '0;

    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("reset_en", bp_if.PDIF_en, 1'b0);
    chk("reset_res", bp_if.PDIF_predict_result, 1'b0);

`ifndef BRANCH_PREDICTOR_GSHARE_EN
    // Held request: one pulse only
    bp_if.IFPD_predict_en = 1'b1;
    bp_if.IFPD_pc         = 32'h100;
    cycle();
    chk("first_req_en", bp_if.PDIF_en, 1'b1);
    chk("first_req_res", bp_if.PDIF_predict_result, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("held_no_pulse", bp_if.PDIF_en, 1'b0);
    end
    bp_if.IFPD_predict_en = 1'b0;
    cycle();

    // Training walk WNT -> WT -> ST -> ST -> WT -> WNT -> SNT
    feedback(32'h100, 1'b1);
    request("after_t1", 32'h100, 1'b1);
    feedback(32'h100, 1'b1);
    feedback(32'h100, 1'b1);
    feedback(32'h100, 1'b0);
    request("st_to_wt", 32'h100, 1'b1);
    feedback(32'h100, 1'b0);
    feedback(32'h100, 1'b0);
    request("to_snt", 32'h100, 1'b0);

    // Aliasing: 0x500 shares index 0x40 with 0x100
    feedback(32'h500, 1'b1);
    feedback(32'h500, 1'b1);
    request("alias", 32'h100, 1'b1);
    request("neighbour", 32'h104, 1'b0);

    // Same-cycle request and feedback: prediction sees pre-update value
    bp_if.IFPD_predict_en    = 1'b1;
    bp_if.IFPD_pc            = 32'h200;
    bp_if.IFPD_feedback_en   = 1'b1;
    bp_if.IFPD_feedback_pc   = 32'h200;
    bp_if.IFPD_branch_result = 1'b1;
    cycle();
    chk("same_cycle_en", bp_if.PDIF_en, 1'b1);
    chk("same_cycle_res", bp_if.PDIF_predict_result, 1'b0);
    bp_if.IFPD_predict_en  = 1'b0;
    bp_if.IFPD_feedback_en = 1'b0;
    cycle();
    request("same_cycle_after", 32'h200, 1'b1);

    // Stall: request and feedback both ignored
    rdy = 1'b0;
    bp_if.IFPD_predict_en    = 1'b1;
    bp_if.IFPD_pc            = 32'h300;
    bp_if.IFPD_feedback_en   = 1'b1;
    bp_if.IFPD_feedback_pc   = 32'h300;
    bp_if.IFPD_branch_result = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_no_pulse", bp_if.PDIF_en, 1'b0);
    end
    rdy = 1'b1;
    bp_if.IFPD_feedback_en = 1'b0;
    cycle();
    chk("post_stall_en", bp_if.PDIF_en, 1'b1);
    chk("post_stall_res", bp_if.PDIF_predict_result, 1'b0);
    bp_if.IFPD_predict_en = 1'b0;
    cycle();

    // Reset mid-request: pulse drops, held request answered anew
    bp_if.IFPD_predict_en = 1'b1;
    bp_if.IFPD_pc         = 32'h100;
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_mid_drop", bp_if.PDIF_en, 1'b0);
    rst = 1'b0;
    cycle();
    chk("rst_mid_renew_en", bp_if.PDIF_en, 1'b1);
    chk("rst_mid_renew_res", bp_if.PDIF_predict_result, 1'b0);
    bp_if.IFPD_predict_en = 1'b0;
    cycle();
`else
    // Gshare: taken at pc 0 trains index 0 and sets history to 1
    feedback(32'h0, 1'b1);
    chk("ghr_bit0", dut.ghr_q[0], 1'b1);
    chk("ghr_hi_zero", |dut.ghr_q[7:1], 1'b0);
    request("gshare_hit", 32'h4, 1'b1);
    request("gshare_other", 32'h8, 1'b0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      bp_if.IFPD_predict_en    = $urandom_range(0, 1);
      bp_if.IFPD_pc            = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      bp_if.IFPD_feedback_en   = $urandom_range(0, 1);
      bp_if.IFPD_feedback_pc   = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      bp_if.IFPD_branch_result = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rst = 1'b0;
    rdy = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
